// File: rtl/sd_fifo_tx_filler_burst.sv
// -----------------------------------------------------------------------------
// sd_fifo_tx_filler_burst
//
// Fetches xfer_words words from system memory as a Wishbone B3 read master
// using incrementing bursts. The words go into an internal synchronous FIFO
// that the SD data serialiser drains with rd.
//
// A burst never crosses a BURST_LEN-word boundary. It is only issued once the
// FIFO has room for every beat, so an acked beat never meets a full FIFO.
//
// Optional feature: define SD_TX_FILLER_ERR_EN to add m_wb_err_i / err and an
// ERROR state that a bus error enters.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   en                level enable: rising edge starts a transfer,
//                     low aborts the transfer and flushes the FIFO
//   adr, xfer_words   byte base address and word count, latched on en rise
//   m_wb_*            Wishbone B3 master (read only, linear incrementing)
//   rd                FIFO pop request
//   dat_o             popped word, registered (1-cycle latency from rd)
//   empty/full/level  FIFO status
//   done              every requested word has been written into the FIFO
//   dbg_state_o       current FSM state, for observation
//
// Handshake: a beat transfers on every clock edge where stb is high and
// m_wb_ack_i is high. A pop happens on every edge where rd is high and the
// FIFO is not empty.
// -----------------------------------------------------------------------------
module sd_fifo_tx_filler_burst #(
  parameter int DW        = 32,
  parameter int AW        = 32,
  parameter int DEPTH     = 16,
  parameter int BURST_LEN = 4,
  parameter int LEN_W     = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [AW-1:0]          adr,
  input  logic [LEN_W-1:0]       xfer_words,
  output logic [AW-1:0]          m_wb_adr_o,
  output logic                   m_wb_we_o,
  output logic [DW/8-1:0]        m_wb_sel_o,
  output logic                   m_wb_cyc_o,
  output logic                   m_wb_stb_o,
  output logic [2:0]             m_wb_cti_o,
  output logic [1:0]             m_wb_bte_o,
  input  logic [DW-1:0]          m_wb_dat_i,
  input  logic                   m_wb_ack_i,
`ifdef SD_TX_FILLER_ERR_EN
  input  logic                   m_wb_err_i,
  output logic                   err,
`endif
  input  logic                   rd,
  output logic [DW-1:0]          dat_o,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] level,
  output logic                   done,
  output logic [2:0]             dbg_state_o
);

  localparam int         PW      = $clog2(DEPTH);
  localparam logic [2:0] CTI_INC = 3'b010;
  localparam logic [2:0] CTI_END = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_BURST = 3'd2,
    S_DONE  = 3'd3
`ifdef SD_TX_FILLER_ERR_EN
    , S_ERROR = 3'd4
`endif
  } state_t;

  state_t           state_q;
  logic             en_q;
  logic [AW-1:0]    base_q;
  logic [AW-1:0]    adr_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] offset_q;
  logic [PW:0]      beats_left_q;
  logic             cyc_q;
  logic             stb_q;
  logic [2:0]       cti_q;
  logic             done_q;
`ifdef SD_TX_FILLER_ERR_EN
  logic             err_q;
`endif

  // FIFO storage; counts are one bit wider than the pointers so that
  // full and empty are distinguishable.
  logic [DW-1:0]    mem_q [DEPTH];
  logic [PW:0]      wr_cnt_q;
  logic [PW:0]      rd_cnt_q;
  logic [DW-1:0]    dat_q;

  logic [PW:0]      level_w;
  logic [PW:0]      space_w;
  logic [PW:0]      beats_w;
  logic [LEN_W-1:0] to_bound_w;
  logic [LEN_W-1:0] remain_w;
  logic [LEN_W-1:0] run_w;
  logic             err_hit;
  logic             beat_ok;
  logic             pop_ok;

  assign level_w = wr_cnt_q - rd_cnt_q;
  assign space_w = (PW+1)'(DEPTH) - level_w;

  // Beats in the next burst: limited by the words left and by the distance
  // to the next BURST_LEN-aligned word offset.
  assign to_bound_w = LEN_W'(BURST_LEN) - (offset_q & LEN_W'(BURST_LEN - 1));
  assign remain_w   = len_q - offset_q;
  assign run_w      = (remain_w < to_bound_w) ? remain_w : to_bound_w;
  assign beats_w    = (PW+1)'(run_w);

`ifdef SD_TX_FILLER_ERR_EN
  assign err_hit = m_wb_err_i && (state_q == S_BURST);
`else
  assign err_hit = 1'b0;
`endif

  // A full FIFO blocks the write even though the space check should make
  // that impossible; a misbehaving slave then cannot corrupt the pointers.
  assign beat_ok = en && (state_q == S_BURST) && m_wb_ack_i && !level_w[PW] && !err_hit;
  assign pop_ok  = en && rd && (level_w != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      en_q         <= 1'b0;
      base_q       <= '0;
      adr_q        <= '0;
      len_q        <= '0;
      offset_q     <= '0;
      beats_left_q <= '0;
      cyc_q        <= 1'b0;
      stb_q        <= 1'b0;
      cti_q        <= 3'b000;
      done_q       <= 1'b0;
`ifdef SD_TX_FILLER_ERR_EN
      err_q        <= 1'b0;
`endif
    end else begin
      en_q <= en;
      if (!en) begin
        // Abort: any beat acked on this edge is dropped with the flush.
        state_q      <= S_IDLE;
        offset_q     <= '0;
        beats_left_q <= '0;
        cyc_q        <= 1'b0;
        stb_q        <= 1'b0;
        cti_q        <= 3'b000;
        done_q       <= 1'b0;
`ifdef SD_TX_FILLER_ERR_EN
        err_q        <= 1'b0;
`endif
      end else begin
        case (state_q)
          S_IDLE: begin
            if (!en_q) begin
              base_q   <= adr;
              len_q    <= xfer_words;
              offset_q <= '0;
              if (xfer_words == '0) begin
                state_q <= S_DONE;
                done_q  <= 1'b1;
              end else begin
                state_q <= S_WAIT;
              end
            end
          end
          S_WAIT: begin
            if (space_w >= beats_w) begin
              state_q      <= S_BURST;
              cyc_q        <= 1'b1;
              stb_q        <= 1'b1;
              adr_q        <= base_q + AW'(offset_q) * AW'(DW / 8);
              cti_q        <= (beats_w == (PW+1)'(1)) ? CTI_END : CTI_INC;
              beats_left_q <= beats_w;
            end
          end
          S_BURST: begin
`ifdef SD_TX_FILLER_ERR_EN
            if (err_hit) begin
              state_q <= S_ERROR;
              cyc_q   <= 1'b0;
              stb_q   <= 1'b0;
              cti_q   <= 3'b000;
              err_q   <= 1'b1;
            end else
`endif
            if (beat_ok) begin
              offset_q     <= offset_q + LEN_W'(1);
              adr_q        <= adr_q + AW'(DW / 8);
              beats_left_q <= beats_left_q - (PW+1)'(1);
              if (beats_left_q == (PW+1)'(1)) begin
                cyc_q <= 1'b0;
                stb_q <= 1'b0;
                cti_q <= 3'b000;
                if (offset_q + LEN_W'(1) == len_q) begin
                  state_q <= S_DONE;
                  done_q  <= 1'b1;
                end else begin
                  state_q <= S_WAIT;
                end
              end else begin
                // Two beats left before this ack means the next one is last.
                cti_q <= (beats_left_q == (PW+1)'(2)) ? CTI_END : CTI_INC;
              end
            end
          end
          S_DONE: begin
            cyc_q <= 1'b0;
            stb_q <= 1'b0;
          end
`ifdef SD_TX_FILLER_ERR_EN
          S_ERROR: begin
            cyc_q <= 1'b0;
            stb_q <= 1'b0;
          end
`endif
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (beat_ok) mem_q[wr_cnt_q[PW-1:0]] <= m_wb_dat_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      dat_q    <= '0;
    end else if (!en) begin
      // Flush the FIFO; dat_o keeps the last popped word.
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
    end else begin
      if (beat_ok) wr_cnt_q <= wr_cnt_q + (PW+1)'(1);
      if (pop_ok) begin
        rd_cnt_q <= rd_cnt_q + (PW+1)'(1);
        dat_q    <= mem_q[rd_cnt_q[PW-1:0]];
      end
    end
  end

  assign m_wb_adr_o  = adr_q;
  assign m_wb_we_o   = 1'b0;
  assign m_wb_sel_o  = {(DW/8){1'b1}};
  assign m_wb_cyc_o  = cyc_q;
  assign m_wb_stb_o  = stb_q;
  assign m_wb_cti_o  = cti_q;
  assign m_wb_bte_o  = 2'b00;
  assign dat_o       = dat_q;
  assign level       = level_w;
  assign empty       = (level_w == '0);
  assign full        = level_w[PW];
  assign done        = done_q;
  assign dbg_state_o = state_q;
`ifdef SD_TX_FILLER_ERR_EN
  assign err         = err_q;
`endif

endmodule

// File: tb/tb_sd_fifo_tx_filler_burst.sv
// -----------------------------------------------------------------------------
// Bench for sd_fifo_tx_filler_burst (default parameters).
//
// The bench models the transfer as an ordered list of expected beats. Each
// beat is {address, cti}, and the list is built from the base address, the
// word count and the BURST_LEN boundary rule. The FIFO is modelled as a
// queue. The bench acts as a Wishbone slave with a random ack rate.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sd_fifo_tx_filler_burst;
  localparam int DW = 32, AW = 32, DEPTH = 16, BL = 4, LEN_W = 16;
  localparam int LW = $clog2(DEPTH) + 1;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic             en = 1'b0;
  logic             rd = 1'b0;
  logic [AW-1:0]    base_i = '0;
  logic [LEN_W-1:0] len_i = '0;
  logic             ack = 1'b0;
  logic             err_in = 1'b0;
  logic [DW-1:0]    wdat = '0;

  logic [AW-1:0]    m_adr;
  logic             we, cyc, stb;
  logic [DW/8-1:0]  sel;
  logic [2:0]       cti;
  logic [1:0]       bte;
  logic [DW-1:0]    dat_o;
  logic             empty, full, done;
  logic [LW-1:0]    level;
  logic [2:0]       dbg_state;
`ifdef SD_TX_FILLER_ERR_EN
  logic             err;
`endif

  sd_fifo_tx_filler_burst #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .BURST_LEN(BL), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .en(en), .adr(base_i), .xfer_words(len_i),
    .m_wb_adr_o(m_adr), .m_wb_we_o(we), .m_wb_sel_o(sel), .m_wb_cyc_o(cyc),
    .m_wb_stb_o(stb), .m_wb_cti_o(cti), .m_wb_bte_o(bte),
    .m_wb_dat_i(wdat), .m_wb_ack_i(ack),
`ifdef SD_TX_FILLER_ERR_EN
    .m_wb_err_i(err_in), .err(err),
`endif
    .rd(rd), .dat_o(dat_o), .empty(empty), .full(full), .level(level),
    .done(done), .dbg_state_o(dbg_state)
  );

  // model state
  typedef struct packed { logic [AW-1:0] a; logic [2:0] c; } beat_t;
  beat_t         beat_q[$];   // beats still expected in this transfer
  beat_t         dut_log[$];  // beats the DUT actually transferred
  logic [DW-1:0] exp_q[$];    // FIFO contents
  logic [DW-1:0] exp_dat;
  bit            exp_done, exp_err, en_prev;
  int            beat_cnt;
  logic          stb_s;
  logic [AW-1:0] adr_s;
  logic [2:0]    cti_s;
  int            n_vec = 0, n_bad = 0;
  int            ack_pct = 100;
  bit            err_arm = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
    end
  endtask

  function automatic void model_reset();
    beat_q.delete();
    exp_q.delete();
    exp_dat  = '0;
    exp_done = 1'b0;
    exp_err  = 1'b0;
    en_prev  = 1'b0;
    beat_cnt = 0;
  endfunction

  // model update on the active edge, from inputs and the outputs captured
  // on the preceding falling edge
  always @(posedge clk) begin
    if (rst) begin
      model_reset();
    end else begin
      if (!en) begin
        beat_q.delete();
        exp_q.delete();
        exp_done = 1'b0;
        exp_err  = 1'b0;
      end else if (!en_prev) begin
        beat_q.delete();
        beat_cnt = 0;
        for (int o = 0; o < int'(len_i); o++)
          beat_q.push_back('{a: base_i + AW'(4 * o),
                             c: (((o + 1) % BL == 0) || (o + 1 == int'(len_i))) ? 3'b111 : 3'b010});
        exp_done = (len_i == '0);
      end else begin
        bit wr_ok, rd_ok;
        wr_ok = stb_s && ack && !err_in && (exp_q.size() < DEPTH);
        rd_ok = rd && (exp_q.size() > 0);
        if (rd_ok) exp_dat = exp_q.pop_front();
        if (stb_s && err_in) begin
          beat_q.delete();
          exp_err = 1'b1;
        end else if (wr_ok) begin
          if (beat_q.size() == 0) begin
            chk("extra_beat", 1, 0);
          end else begin
            beat_t b;
            b = beat_q.pop_front();
            beat_cnt = (b.c == 3'b111) ? 0 : beat_cnt + 1;
          end
          dut_log.push_back('{a: adr_s, c: cti_s});
          exp_q.push_back(wdat);
          if (beat_q.size() == 0) exp_done = 1'b1;
        end
      end
      en_prev = en;
    end
  end

  // compare on the falling edge, then capture bus state and drive the slave
  always @(negedge clk) begin
    if (!rst) begin
      chk("level", level, exp_q.size());
      chk("empty", empty, exp_q.size() == 0);
      chk("full", full, exp_q.size() == DEPTH);
      chk("dat_o", dat_o, exp_dat);
      chk("done", done, exp_done);
      chk("cyc_eq_stb", cyc, stb);
      chk("static_bus", {we, sel, bte}, {1'b0, 4'hf, 2'b00});
`ifdef SD_TX_FILLER_ERR_EN
      chk("err", err, exp_err);
`endif
      if (exp_done || exp_err) chk("bus_idle", cyc, 0);
      if (stb) begin
        if (beat_q.size() == 0) begin
          chk("unexpected_stb", 1, 0);
        end else begin
          chk("adr", m_adr, beat_q[0].a);
          chk("cti", cti, beat_q[0].c);
          if (!stb_s) begin
            int n;
            n = 1;
            while (n < beat_q.size() && beat_q[n-1].c != 3'b111) n++;
            chk("burst_space", (DEPTH - exp_q.size()) >= n, 1);
          end
        end
      end
    end
    stb_s  = stb;
    adr_s  = m_adr;
    cti_s  = cti;
    ack    = 1'b0;
    err_in = 1'b0;
    wdat   = $urandom;
    if (stb && !rst) begin
      if (err_arm && beat_cnt == 2) err_in = 1'b1;
      else ack = ($urandom_range(0, 99) < ack_pct);
    end
  end

  // driver tasks
  task automatic start(input logic [AW-1:0] a, input int n);
    @(negedge clk); en = 1'b0;
    @(negedge clk); base_i = a; len_i = LEN_W'(n); en = 1'b1;
  endtask

  task automatic wait_done(input int maxc);
    int c = 0;
    while (!done && c < maxc) begin @(negedge clk); c++; end
    chk("done_timeout", done, 1);
  endtask

  task automatic wait_beats(input int n, input int maxc);
    int c = 0;
    while (dut_log.size() < n && c < maxc) begin @(negedge clk); c++; end
    chk("beats_timeout", dut_log.size() >= n, 1);
  endtask

  task automatic read_n(input int n);
    for (int i = 0; i < n; i++) begin @(negedge clk); rd = 1'b1; end
    @(negedge clk); rd = 1'b0;
  endtask

  task automatic drain(input int maxc);
    int c = 0;
    rd = 1'b1;
    while (!empty && c < maxc) begin @(negedge clk); c++; end
    rd = 1'b0;
    @(negedge clk);
    chk("drain_empty", empty, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] old;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // reset then idle
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      chk("rst_adr", m_adr, 0);
      chk("rst_cti", cti, 0);
      chk("rst_cyc", cyc, 0);
      chk("rst_stb", stb, 0);
    end

    // basic transfer
    ack_pct = 100;
    dut_log.delete();
    start(32'h1000, 8);
    wait_done(200);
    @(negedge clk); #1;
    chk("basic_level", level, 8);
    chk("basic_nbeats", dut_log.size(), 8);
    for (int i = 0; i < 8; i++) begin
      chk("basic_adr", dut_log[i].a, 32'h1000 + 4 * i);
      chk("basic_cti", dut_log[i].c, (i % 4 == 3) ? 3'b111 : 3'b010);
    end
    drain(20);

    // back-pressure
    dut_log.delete();
    start(32'h3000, 40);
    repeat (60) @(negedge clk);
    #1;
    chk("bp_level_full", level, 16);
    chk("bp_cyc_idle", cyc, 0);
    chk("bp_nbeats16", dut_log.size(), 16);
    read_n(4);
    repeat (20) @(negedge clk);
    #1;
    chk("bp_nbeats20", dut_log.size(), 20);
    chk("bp_level_refill", level, 16);
    rd = 1'b1;
    wait_done(400);
    drain(40);

    // odd length
    dut_log.delete();
    start(32'h1000, 6);
    wait_done(100);
    chk("odd_nbeats", dut_log.size(), 6);
    chk("odd_cti3", dut_log[3].c, 3'b111);
    chk("odd_adr4", dut_log[4].a, 32'h1010);
    chk("odd_cti4", dut_log[4].c, 3'b010);
    chk("odd_adr5", dut_log[5].a, 32'h1014);
    chk("odd_cti5", dut_log[5].c, 3'b111);
    drain(20);

    // abort mid-burst
    dut_log.delete();
    start(32'h1000, 8);
    wait_beats(2, 50);
    en = 1'b0;
    @(negedge clk); #1;
    chk("abort_cyc", cyc, 0);
    chk("abort_level", level, 0);
    chk("abort_empty", empty, 1);
    chk("abort_done", done, 0);
    dut_log.delete();
    start(32'h2000, 5);
    wait_done(100);
    chk("restart_adr0", dut_log[0].a, 32'h2000);
    chk("restart_adr4", dut_log[4].a, 32'h2010);
    drain(20);

    // ack and rd together on an empty FIFO
    old = exp_dat;
    rd = 1'b1;
    dut_log.delete();
    start(32'h4000, 4);
    wait_beats(1, 50);
    #1;
    chk("simul_level", level, 1);
    chk("simul_dat_hold", dat_o, old);
    wait_done(100);
    drain(20);

    // asynchronous reset mid-burst
    dut_log.delete();
    start(32'h5000, 8);
    wait_beats(1, 50);
    #2 rst = 1'b1;
    model_reset();
    #1;
    chk("arst_cyc", cyc, 0);
    chk("arst_stb", stb, 0);
    chk("arst_level", level, 0);
    chk("arst_dat", dat_o, 0);
    @(negedge clk); rst = 1'b0;
    wait_done(200);
    drain(20);

`ifdef SD_TX_FILLER_ERR_EN
    // bus error on the third beat
    err_arm = 1'b1;
    start(32'h6000, 8);
    begin
      int c = 0;
      while (!err && c < 50) begin @(negedge clk); c++; end
    end
    #1;
    chk("err_flag", err, 1);
    chk("err_cyc", cyc, 0);
    chk("err_done", done, 0);
    chk("err_level", level, 2);
    err_arm = 1'b0;
`endif

    // randomized transfers
    for (int t = 0; t < 30; t++) begin
      int rd_pct;
      ack_pct = $urandom_range(30, 100);
      rd_pct  = $urandom_range(20, 100);
      start($urandom & 32'hFFFF_FFFC, $urandom_range(0, 40));
      for (int c = 0; c < 800; c++) begin
        @(negedge clk);
        rd = ($urandom_range(0, 99) < rd_pct);
        if ($urandom_range(0, 299) == 0) break;
        if (exp_done && exp_q.size() == 0) break;
      end
      rd = 1'b0;
    end

    @(negedge clk); en = 1'b0;
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
